des_round_sequencer: RTL and testbench
======================================

// Module: des_round_sequencer
// PURPOSE
//  Control FSM for the iterative (one round/cycle) DES core. Sequences IP/PC1 load, 16 Feistel rounds
//  with per-round key-rotation control (enc: rotate left, dec: rotate right), then final-permutation
//  capture. Owns the valid/ready handshake on both sides. Carries a user tag per block and counts completed blocks.
// PARAMETERS
//  TAG_W   4   width of per-block tag carried from start to output
//  BCNT_W  16  width of saturating completed-block counter
// PORTS
//  clk            in   1       clock, rising edge
//  rst            in   1       synchronous reset, active-high
//  start_valid    in   1       new block (plaintext/ciphertext + key) present on datapath inputs
//  start_ready    out  1       sequencer accepts block this cycle
//  start_decrypt  in   1       0=encrypt, 1=decrypt; sampled on start handshake
//  start_tag      in   TAG_W   user tag; sampled on start handshake
//  load_state     out  1       datapath: L/R <= IP(block), C/D <= PC1(key)
//  round_en       out  1       datapath: perform one Feistel round, write back rotated C/D
//  round_idx      out  4       current round 0..15 (0 outside ROUND)
//  key_shift      out  2       C/D rotation amount this round (0,1,2)
//  key_dir        out  1       rotation direction: 0=left (enc), 1=right (dec); latched mode
//  out_capture    out  1       datapath: out_reg <= final permutation of {R16,L16}
//  out_valid      out  1       result in out_reg valid
//  out_ready      in   1       consumer accepts result
//  out_tag        out  TAG_W   tag of block in out_reg
//  busy           out  1       state != IDLE
//  done_count     out  BCNT_W  completed-block counter, saturating
// BEHAVIOUR
//  Reset: state=IDLE; every output 0 while rst=1 (start_ready gated low); done_count=0, tag/mode regs=0.
//  States IDLE, LOAD, ROUND, FINAL, HOLD.
//  IDLE : start_ready=1. start_valid -> latch decrypt/tag, go LOAD.
//  LOAD : one cycle, load_state=1 -> ROUND, round_idx=0.
//  ROUND: 16 cycles, round_en=1, round_idx 0..15 increments each cycle; idx 15 -> FINAL.
//   key_shift enc: idx{0,1,8,15}=1, else 2 (sum 28).
//   key_shift dec: idx0=0, idx{1,8,15}=1, else 2 (sum 27). key_shift=0 outside ROUND.
//  FINAL: one cycle, out_capture=1 -> HOLD.
//  HOLD : out_valid=1, out_tag stable. start_ready=out_ready (overlap allowed).
//   out_ready & start_valid -> accept new block, go LOAD; out_ready & !start_valid -> IDLE;
//   !out_ready -> stay, all strobes 0.
//  Latency: handshake at cycle T -> load_state T+1, round_en T+2..T+17, out_capture T+18, out_valid T+19.
//  Throughput: one block per 19 cycles with start_valid and out_ready held high.
//  done_count += 1 on out_valid&out_ready; holds at 2^BCNT_W-1.
//  start_valid outside IDLE/HOLD ignored (start_ready=0); inputs sampled only on handshake.
//  rst mid-operation: block discarded, no out_valid, FSM to IDLE next cycle.
//  Strobes load_state/round_en/out_capture mutually exclusive, never with rst=1.
// TESTING
//  1 rst pulse at round_idx=7 -> next cycle all outputs 0; start_ready=1 first cycle after rst falls.
//  2 enc, tag=5, key 133457799BBCDFF1, pt 0123456789ABCDEF -> shifts 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1 key_dir=0;
//    out_valid at T+19, out_tag=5, result 85E813540F0AB405.
//  3 dec same key, ct 85E813540F0AB405 -> shifts 0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1 key_dir=1; result 0123456789ABCDEF.
//  4 out_ready=0 for 10 cycles in HOLD -> out_valid, out_tag stable, start_ready=0, no load_state pulses.
//  5 start_valid, out_ready held 1, 3 blocks -> out_valid pulses 19 cycles apart, tags in order.
//  6 BCNT_W=2, 5 completed blocks -> done_count 1,2,3,3,3.

Source files
------------

// File: rtl/des_round_sequencer.sv
// des_round_sequencer: control FSM for an iterative one-round-per-cycle DES core
// Sequences load, 16 Feistel rounds with key rotation control, final capture and result hold.
module des_round_sequencer #(
   parameter int TAG_W  = 4,
   parameter int BCNT_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_valid,
   output logic              start_ready,
   input  logic              start_decrypt,
   input  logic [TAG_W-1:0]  start_tag,
   output logic              load_state,
   output logic              round_en,
   output logic [3:0]        round_idx,
   output logic [1:0]        key_shift,
   output logic              key_dir,
   output logic              out_capture,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [TAG_W-1:0]  out_tag,
   output logic              busy,
   output logic [BCNT_W-1:0] done_count
);
   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] LOAD  = 3'd1;
   localparam logic [2:0] ROUND = 3'd2;
   localparam logic [2:0] FINAL = 3'd3;
   localparam logic [2:0] HOLD  = 3'd4;
   logic [2:0]        state;
   logic [3:0]        idx;
   logic              dec;
   logic [TAG_W-1:0]  tag;
   logic [BCNT_W-1:0] cnt;
   logic              accept, retire, one_shift;
   // Every output is gated by rst so nothing leaks out while reset is held.
   always_comb begin
      start_ready = !rst && (state == IDLE || (state == HOLD && out_ready));
      accept      = start_ready && start_valid;
      retire      = !rst && state == HOLD && out_ready;
      load_state  = !rst && state == LOAD;
      round_en    = !rst && state == ROUND;
      round_idx   = round_en ? idx : 4'd0;
      one_shift   = idx == 4'd0 || idx == 4'd1 || idx == 4'd8 || idx == 4'd15;
      // Decryption skips the first rotation so right shifts walk the encrypt schedule backwards.
      key_shift   = !round_en ? 2'd0 : (dec && idx == 4'd0) ? 2'd0 : one_shift ? 2'd1 : 2'd2;
      key_dir     = !rst && dec;
      out_capture = !rst && state == FINAL;
      out_valid   = !rst && state == HOLD;
      out_tag     = rst ? '0 : tag;
      busy        = !rst && state != IDLE;
      done_count  = rst ? '0 : cnt;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         idx   <= 4'd0;
         dec   <= 1'b0;
         tag   <= '0;
         cnt   <= '0;
      end else begin
         if (accept) begin
            dec <= start_decrypt;
            tag <= start_tag;
         end
         if (retire && cnt != '1)
            cnt <= cnt + 1'b1;
         idx   <= (state == ROUND) ? idx + 4'd1 : 4'd0;
         state <= accept                             ? LOAD  :
                  state == LOAD                      ? ROUND :
                  (state == ROUND && idx == 4'd15)   ? FINAL :
                  state == FINAL                     ? HOLD  :
                  retire                             ? IDLE  : state;
      end
   end
endmodule

// File: tb/tb_des_round_sequencer.sv
// tb_des_round_sequencer: table vectors, directed corner sequences and a random run
// checked every cycle against a cycles-since-accept reference model.
module tb_des_round_sequencer;
   logic        clk = 1'b0, rst = 1'b1;
   logic        start_valid = 1'b0, start_decrypt = 1'b0, out_ready = 1'b0;
   logic [3:0]  start_tag = 4'd0;
   logic        start_ready, load_state, round_en, key_dir, out_capture, out_valid, busy;
   logic [3:0]  round_idx, out_tag;
   logic [1:0]  key_shift;
   logic [15:0] done_count;
   logic        start_ready_b, load_state_b, round_en_b, key_dir_b, out_capture_b, out_valid_b, busy_b;
   logic [3:0]  round_idx_b, out_tag_b;
   logic [1:0]  key_shift_b;
   logic [1:0]  done_count_b;

   des_round_sequencer #(.TAG_W(4), .BCNT_W(16)) u_dut (
      .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(start_ready),
      .start_decrypt(start_decrypt), .start_tag(start_tag), .load_state(load_state),
      .round_en(round_en), .round_idx(round_idx), .key_shift(key_shift), .key_dir(key_dir),
      .out_capture(out_capture), .out_valid(out_valid), .out_ready(out_ready),
      .out_tag(out_tag), .busy(busy), .done_count(done_count));

   des_round_sequencer #(.TAG_W(4), .BCNT_W(2)) u_dut_b (
      .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(start_ready_b),
      .start_decrypt(start_decrypt), .start_tag(start_tag), .load_state(load_state_b),
      .round_en(round_en_b), .round_idx(round_idx_b), .key_shift(key_shift_b), .key_dir(key_dir_b),
      .out_capture(out_capture_b), .out_valid(out_valid_b), .out_ready(out_ready),
      .out_tag(out_tag_b), .busy(busy_b), .done_count(done_count_b));

   always #5 clk = ~clk;

   int checks = 0, errors = 0;
   int enc_sh[16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
   int dec_sh[16] = '{0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a block is described only by cycles elapsed since its handshake.
   bit         m_act = 0, m_dec = 0, u_hold;
   int         m_c = 0, m_cnt = 0;
   logic [3:0] m_tag = 4'd0;
   bit         e_hold, e_round;
   int         e_idx;

   always @(posedge clk) begin
      if (rst) begin
         m_act <= 0; m_c <= 0; m_tag <= 4'd0; m_dec <= 0; m_cnt <= 0;
      end else begin
         u_hold = m_act && m_c >= 19;
         if (u_hold && out_ready) m_cnt <= m_cnt + 1;
         if ((!m_act || (u_hold && out_ready)) && start_valid) begin
            m_act <= 1; m_c <= 1; m_tag <= start_tag; m_dec <= start_decrypt;
         end else if (u_hold && out_ready) begin
            m_act <= 0; m_c <= 0;
         end else if (m_act && m_c < 19) begin
            m_c <= m_c + 1;
         end
      end
   end

   always @(negedge clk) begin
      e_hold  = !rst && m_act && m_c >= 19;
      e_round = !rst && m_act && m_c >= 2 && m_c <= 17;
      e_idx   = e_round ? m_c - 2 : 0;
      chk("mon_start_ready", start_ready, !rst && (!m_act || (e_hold && out_ready)));
      chk("mon_load_state", load_state, !rst && m_act && m_c == 1);
      chk("mon_round_en", round_en, e_round);
      chk("mon_round_idx", round_idx, e_idx);
      chk("mon_key_shift", key_shift, e_round ? (m_dec ? dec_sh[e_idx] : enc_sh[e_idx]) : 0);
      chk("mon_key_dir", key_dir, !rst && m_dec);
      chk("mon_out_capture", out_capture, !rst && m_act && m_c == 18);
      chk("mon_out_valid", out_valid, e_hold);
      chk("mon_out_tag", out_tag, rst ? 0 : m_tag);
      chk("mon_busy", busy, !rst && m_act);
      chk("mon_done_count", done_count, rst ? 0 : (m_cnt > 65535 ? 65535 : m_cnt));
      chk("mon_done_count_sat", done_count_b, rst ? 0 : (m_cnt > 3 ? 3 : m_cnt));
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic start_block(input bit d, input logic [3:0] t);
      int n;
      start_valid = 1'b1; start_decrypt = d; start_tag = t;
      for (n = 0; n < 50; n++) begin
         #1;
         if (start_ready) break;
         cyc();
      end
      if (n == 50) chk("start_timeout", 0, 1);
      cyc();
      start_valid = 1'b0;
   endtask

   task automatic wait_ov();
      int n;
      for (n = 0; n < 40; n++) begin
         #1;
         if (out_valid) break;
         cyc();
      end
      if (n == 40) chk("out_valid_timeout", 0, 1);
   endtask

   typedef struct {
      bit         dec;
      logic [3:0] tag;
      int         exp_sum;
      bit         exp_dir;
   } vec_t;

   vec_t vecs[4];

   initial begin
      int lat, sum, k, hs, cnt_ov;
      bit take;
      int ov_t[$];
      logic [3:0] ov_tag[$];
      vecs[0] = '{dec: 1'b0, tag: 4'd5, exp_sum: 28, exp_dir: 1'b0};
      vecs[1] = '{dec: 1'b1, tag: 4'd5, exp_sum: 27, exp_dir: 1'b1};
      vecs[2] = '{dec: 1'b0, tag: 4'hA, exp_sum: 28, exp_dir: 1'b0};
      vecs[3] = '{dec: 1'b1, tag: 4'h3, exp_sum: 27, exp_dir: 1'b1};

      repeat (3) cyc();
      #1;
      chk("rst_start_ready", start_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done_count", done_count, 0);
      rst = 1'b0;
      #1;
      chk("post_rst_start_ready", start_ready, 1);
      cyc();

      // Encrypt/decrypt schedules, latency and tag from the vector table.
      foreach (vecs[v]) begin
         out_ready = 1'b0;
         start_block(vecs[v].dec, vecs[v].tag);
         lat = 1; sum = 0; k = 0;
         for (int n = 0; n < 30; n++) begin
            #1;
            if (load_state) chk("vec_load_lat", lat, 1);
            if (out_capture) chk("vec_capture_lat", lat, 18);
            if (round_en) begin
               chk("vec_round_idx", round_idx, k);
               chk("vec_key_shift", key_shift, vecs[v].dec ? dec_sh[k % 16] : enc_sh[k % 16]);
               sum += key_shift;
               k++;
            end
            if (out_valid) break;
            cyc();
            lat++;
         end
         chk("vec_latency", lat, 19);
         chk("vec_rounds", k, 16);
         chk("vec_shift_sum", sum, vecs[v].exp_sum);
         chk("vec_key_dir", key_dir, vecs[v].exp_dir);
         chk("vec_out_tag", out_tag, vecs[v].tag);
         out_ready = 1'b1;
         cyc();
         out_ready = 1'b0;
         #1;
         chk("vec_back_idle", busy, 0);
         cyc();
      end

      // Reset in the middle of round 7 drops the block.
      start_block(1'b0, 4'd1);
      for (int n = 0; n < 20; n++) begin
         #1;
         if (round_idx == 4'd7) break;
         cyc();
      end
      chk("mid_rst_at_idx7", round_idx, 7);
      rst = 1'b1;
      #1;
      chk("mid_rst_round_en", round_en, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_start_ready", start_ready, 0);
      cyc();
      rst = 1'b0;
      #1;
      chk("mid_rst_ready_after", start_ready, 1);
      chk("mid_rst_idle", busy, 0);
      cnt_ov = 0;
      out_ready = 1'b1;
      for (int n = 0; n < 25; n++) begin
         cyc();
         if (out_valid) cnt_ov++;
      end
      chk("mid_rst_no_out_valid", cnt_ov, 0);
      out_ready = 1'b0;

      // Stall in HOLD for 10 cycles with a new block waiting.
      start_block(1'b0, 4'd7);
      wait_ov();
      start_valid = 1'b1; start_tag = 4'd9;
      for (int n = 0; n < 10; n++) begin
         #1;
         chk("stall_out_valid", out_valid, 1);
         chk("stall_out_tag", out_tag, 7);
         chk("stall_start_ready", start_ready, 0);
         chk("stall_load_state", load_state, 0);
         cyc();
      end
      out_ready = 1'b1;
      #1;
      chk("stall_release_ready", start_ready, 1);
      cyc();
      start_valid = 1'b0; out_ready = 1'b0;
      #1;
      chk("overlap_load", load_state, 1);
      chk("overlap_no_out_valid", out_valid, 0);
      chk("overlap_new_tag", out_tag, 9);
      wait_ov();
      chk("overlap_result_tag", out_tag, 9);
      out_ready = 1'b1;
      cyc();

      // Back-to-back blocks with both sides always ready.
      hs = 0; start_tag = 4'd1; start_decrypt = 1'b0; start_valid = 1'b1;
      for (int i = 0; i < 80; i++) begin
         #1;
         if (out_valid) begin
            ov_t.push_back(i);
            ov_tag.push_back(out_tag);
         end
         take = start_ready && start_valid;
         cyc();
         if (take) begin
            hs++;
            if (hs == 3) start_valid = 1'b0;
            else start_tag = start_tag + 4'd1;
         end
      end
      chk("b2b_pulses", ov_t.size(), 3);
      if (ov_t.size() == 3) begin
         chk("b2b_gap1", ov_t[1] - ov_t[0], 19);
         chk("b2b_gap2", ov_t[2] - ov_t[1], 19);
         chk("b2b_tag0", ov_tag[0], 1);
         chk("b2b_tag1", ov_tag[1], 2);
         chk("b2b_tag2", ov_tag[2], 3);
      end

      // Saturating counter on the 2-bit instance.
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      out_ready = 1'b1;
      for (int b = 0; b < 5; b++) begin
         start_block(b[0], 4'(b));
         wait_ov();
         cyc();
         #1;
         chk("sat_done_count_b", done_count_b, b + 1 > 3 ? 3 : b + 1);
         chk("sat_done_count", done_count, b + 1);
      end

      // Random traffic, checked by the cycle monitor.
      for (int i = 0; i < 3000; i++) begin
         rst           = ($urandom_range(0, 199) == 0);
         start_valid   = ($urandom_range(0, 2) == 0);
         start_decrypt = $urandom_range(0, 1);
         start_tag     = 4'($urandom_range(0, 15));
         out_ready     = ($urandom_range(0, 3) != 0);
         cyc();
      end
      rst = 1'b1;
      cyc();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
